// File: rtl/seq_match_pkg.sv
// rtl/seq_match_pkg.sv - shared FSM state type and default sizing for the sequence matcher
package seq_match_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin selector, search starts after i_last
module rr_arbiter
    import seq_match_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_gnt
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = IDX_W'((int'(i_last) + i) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_match_arbiter.sv
// rtl/seq_match_arbiter.sv - shared serial pattern matcher time-multiplexed across requesters
module seq_match_arbiter
    import seq_match_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int PAT_W = DEF_PAT_W,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_we,
    input  logic [PAT_W-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0] i_cfg_len,
    input  logic [NREQ-1:0]  i_req,
    input  logic [NREQ-1:0]  i_bit_in,
    input  logic [NREQ-1:0]  i_bit_valid,
    input  logic [NREQ-1:0]  i_bit_last,
    output logic [NREQ-1:0]  o_gnt,
    output logic             o_match,
    output logic [IDX_W-1:0] o_match_id,
    output logic             o_busy,
    input  logic             i_cnt_clr,
    input  logic [IDX_W-1:0] i_cnt_sel,
    output logic [CNT_W-1:0] o_cnt_rdata
);

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_idx, r_last, r_match_id, w_win_idx;
    logic [PAT_W-1:0] r_pattern, r_hist, w_hist_nxt, w_mask;
    logic [LEN_W-1:0] r_len, r_fill, w_fill_nxt;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt [NREQ];
    logic [NREQ-1:0]  w_winner;
    logic             w_req_k, w_valid_k, w_last_k, w_bit_k, w_accept, w_hit;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .i_req  (i_req),
        .i_last (r_last),
        .o_gnt  (w_winner)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner[i]) w_win_idx = IDX_W'(i);
        end
    end

    // Only the granted requester's lanes are looked at; all others are ignored.
    always_comb begin
        w_req_k    = i_req[r_idx];
        w_valid_k  = i_bit_valid[r_idx];
        w_last_k   = i_bit_last[r_idx];
        w_bit_k    = i_bit_in[r_idx];
        w_accept   = (r_state == ST_STREAM) && w_req_k && w_valid_k;
        w_hist_nxt = {r_hist[PAT_W-2:0], w_bit_k};
        w_fill_nxt = (r_fill == FULL_LEN) ? r_fill : r_fill + LEN_W'(1);
        w_mask     = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
        w_hit = w_accept && (w_fill_nxt >= r_len)
                && (((w_hist_nxt ^ r_pattern) & w_mask) == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        o_gnt  = '0;
        o_busy = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:   if (!i_cfg_we && |i_req) w_next = ST_GRANT;
            ST_GRANT:  w_next = ST_STREAM;
            ST_STREAM: begin
                o_gnt[r_idx] = 1'b1;
                if (!w_req_k || (w_valid_k && w_last_k)) w_next = ST_DONE;
            end
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx      <= '0;
            r_last     <= IDX_W'(NREQ - 1);
            r_pattern  <= '0;
            r_len      <= FULL_LEN;
            r_hist     <= '0;
            r_fill     <= '0;
            r_match    <= 1'b0;
            r_match_id <= '0;
        end else begin
            r_match <= w_hit;
            if (w_hit) r_match_id <= r_idx;
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_we) begin
                        r_pattern <= i_cfg_pattern;
                        r_len     <= (i_cfg_len == '0 || i_cfg_len > FULL_LEN) ? FULL_LEN : i_cfg_len;
                    end else if (|i_req) begin
                        r_idx <= w_win_idx;
                    end
                end
                ST_GRANT: begin
                    r_hist <= '0;
                    r_fill <= '0;
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        r_hist <= w_hist_nxt;
                        r_fill <= w_fill_nxt;
                    end
                end
                ST_DONE: r_last <= r_idx;
                default: ;
            endcase
        end
    end

    // Clear beats a coincident increment; increments stick at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (i_cnt_clr)
                    r_cnt[i] <= '0;
                else if (w_hit && r_idx == IDX_W'(i) && r_cnt[i] != '1)
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_cnt_rdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i_cnt_sel == IDX_W'(i)) o_cnt_rdata = r_cnt[i];
        end
    end

    assign o_match    = r_match;
    assign o_match_id = r_match_id;

endmodule

// File: tb/tb_seq_match_arbiter.sv
// tb/tb_seq_match_arbiter.sv - directed self-checking bench for seq_match_arbiter
module tb_seq_match_arbiter;

    localparam int NREQ  = 4;
    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int IDX_W = 2;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  bit_in = '0;
    logic [NREQ-1:0]  bit_valid = '0;
    logic [NREQ-1:0]  bit_last = '0;
    logic             cnt_clr = 1'b0;
    logic [IDX_W-1:0] cnt_sel = '0;
    logic [NREQ-1:0]  gnt;
    logic             match;
    logic [IDX_W-1:0] match_id;
    logic             busy;
    logic [CNT_W-1:0] cnt_rdata;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int bits [5] = '{1, 0, 1, 0, 1};

    seq_match_arbiter #(.NREQ(NREQ), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cfg_we      (cfg_we),
        .i_cfg_pattern (cfg_pattern),
        .i_cfg_len     (cfg_len),
        .i_req         (req),
        .i_bit_in      (bit_in),
        .i_bit_valid   (bit_valid),
        .i_bit_last    (bit_last),
        .o_gnt         (gnt),
        .o_match       (match),
        .o_match_id    (match_id),
        .o_busy        (busy),
        .i_cnt_clr     (cnt_clr),
        .i_cnt_sel     (cnt_sel),
        .o_cnt_rdata   (cnt_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cnt_chk(input string tag, input logic [IDX_W-1:0] sel, input logic [31:0] exp);
        cnt_sel = sel;
        #1;
        chk(tag, 32'(cnt_rdata), exp);
    endtask

    task automatic wait_gnt(input string tag, input logic [31:0] exp);
        for (int n = 0; n < 8 && gnt == '0; n++) tick();
        chk(tag, 32'(gnt), exp);
    endtask

    task automatic load_cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        tick();
        cfg_we      = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_match", 32'(match), 0);
        chk("rst_match_id", 32'(match_id), 0);
        cnt_chk("rst_cnt0", 2'd0, 0);
        tick();
        rst_n = 1'b1;

        // round-robin with every requester asking, each stream one bit long
        req = 4'b1111; bit_valid = 4'b1111; bit_last = 4'b1111; bit_in = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            wait_gnt("rr_gnt", 32'(1 << (k % 4)));
            tick();
            chk("rr_gap_gnt", 32'(gnt), 0);
            chk("rr_gap_busy", 32'(busy), 1);
        end
        req = '0; bit_valid = '0; bit_last = '0;
        tick();
        chk("rr_idle_busy", 32'(busy), 0);
        chk("rr_no_match", 32'(match), 0);

        // pattern 101, len 3, overlapping matches on requester 0
        load_cfg(8'b0000_0101, 4'd3);
        req = 4'b0001;
        wait_gnt("s1_gnt", 1);
        for (int i = 0; i < 5; i++) begin
            bit_valid = 4'b0001;
            bit_in    = (bits[i] == 1) ? 4'b0001 : 4'b0000;
            bit_last  = (i == 4) ? 4'b0001 : 4'b0000;
            tick();
            chk("s1_match", 32'(match), (i == 2 || i == 4) ? 1 : 0);
            if (i == 2 || i == 4) chk("s1_match_id", 32'(match_id), 0);
        end
        bit_valid = '0; bit_last = '0; bit_in = '0; req = '0;
        chk("s1_done_gnt", 32'(gnt), 0);
        tick();
        chk("s1_idle_busy", 32'(busy), 0);
        cnt_chk("s1_cnt0", 2'd0, 2);

        // counter saturation on requester 2, then clear against a match
        load_cfg(8'b0000_0001, 4'd1);
        req = 4'b0100;
        wait_gnt("sat_gnt", 4);
        bit_valid = 4'b0100; bit_in = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("sat_match", 32'(match), 1);
        end
        cnt_chk("sat_cnt2", 2'd2, 3);
        cnt_clr = 1'b1; bit_last = 4'b0100;
        tick();
        chk("clr_match", 32'(match), 1);
        cnt_clr = 1'b0;
        cnt_chk("clr_cnt2", 2'd2, 0);
        req = '0; bit_valid = '0; bit_last = '0; bit_in = '0;
        tick();

        // abort: requester 1 drops req after two bits of pattern 111
        load_cfg(8'b0000_0111, 4'd3);
        req = 4'b0110;
        wait_gnt("ab_gnt", 2);
        bit_valid = 4'b0010; bit_in = 4'b0010;
        tick();
        chk("ab_match_b1", 32'(match), 0);
        tick();
        chk("ab_match_b2", 32'(match), 0);
        req = 4'b0100;
        tick();
        chk("ab_done_gnt", 32'(gnt), 0);
        chk("ab_done_busy", 32'(busy), 1);
        chk("ab_done_match", 32'(match), 0);
        bit_valid = '0; bit_in = '0;
        tick();
        chk("ab_idle_busy", 32'(busy), 0);
        chk("ab_idle_match", 32'(match), 0);
        wait_gnt("ab_next_gnt", 4);
        cnt_chk("ab_cnt1", 2'd1, 0);
        req = '0;
        tick();
        tick();

        // cfg_we mid-stream must not replace pattern 111
        req = 4'b0001;
        wait_gnt("cf_gnt", 1);
        bit_valid = 4'b0001; bit_in = 4'b0001;
        cfg_we = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd3;
        tick();
        cfg_we = 1'b0;
        tick();
        bit_last = 4'b0001;
        tick();
        chk("cf_match", 32'(match), 1);
        chk("cf_match_id", 32'(match_id), 0);
        bit_valid = '0; bit_last = '0; bit_in = '0; req = '0;
        cnt_chk("cf_cnt0", 2'd0, 1);
        tick();

        // asynchronous reset in the middle of a stream
        req = 4'b0010;
        wait_gnt("rs_gnt", 2);
        bit_valid = 4'b0010; bit_in = 4'b0010;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_gnt_zero", 32'(gnt), 0);
        chk("rs_busy_zero", 32'(busy), 0);
        cnt_chk("rs_cnt0", 2'd0, 0);
        req = 4'b1111; bit_valid = 4'b1111; bit_last = 4'b1111; bit_in = 4'b0000;
        tick();
        rst_n = 1'b1;
        wait_gnt("rs_first_gnt", 1);
        chk("rs_no_match", 32'(match), 0);
        req = '0; bit_valid = '0; bit_last = '0;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_match_arbiter.md
SEQ_MATCH_ARBITER -- requirements
Module: seq_match_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the matcher.
REQ-002 Parameter PAT_W, default 8, maximum pattern length in bits.
REQ-003 Parameter CNT_W, default 8, width of each per-requester match counter.
REQ-004 clock  in  1  single clock; all state on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cfg_we  in  1  pattern/length load strobe.
REQ-007 cfg_pattern  in  PAT_W  pattern; bit 0 = most recent bit.
REQ-008 cfg_len  in  $clog2(PAT_W)+1  pattern length.
REQ-009 req  in  NREQ  per-requester stream request.
REQ-010 bit_in, bit_valid, bit_last  in  NREQ each  per-requester serial data, valid, and end-of-stream marker.
REQ-011 gnt  out  NREQ  one-hot grant.
REQ-012 match  out  1  one-cycle match pulse.
REQ-013 match_id  out  $clog2(NREQ)  requester that produced the match.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 cnt_clr  in  1  clear all match counters.
REQ-016 cnt_sel  in  $clog2(NREQ)  counter read select.
REQ-017 cnt_rdata  out  CNT_W  selected counter value, combinational from cnt_sel.

Function
REQ-018 FSM states: IDLE, GRANT, STREAM, DONE.
REQ-019 IDLE, cfg_we=1: load pattern and length; stay IDLE; cfg_we has priority over req.
  - cfg_len of 0 or greater than PAT_W loads as PAT_W.
REQ-020 IDLE, cfg_we=0, any req bit set: select winner by round-robin; go to GRANT.
  - Search starts at the index after the last granted requester (index 0 after reset).
REQ-021 GRANT: assert gnt[k] from the next cycle; clear history and fill count; go to STREAM.
REQ-022 STREAM, each cycle bit_valid[k]=1: shift bit_in[k] into history bit 0; fill count saturates at PAT_W; bits from non-granted requesters are ignored.
REQ-023 Match condition: fill count including the new bit >= len, and the low len bits of history equal the low len bits of pattern.
  - match and match_id registered; both asserted in the cycle after the accepted bit.
  - Overlapping matches count.
REQ-024 On a match, counter[k] increments and saturates at 2^CNT_W-1.
  - If cnt_clr is asserted in the same cycle, the clear wins and the counter becomes 0.
REQ-025 STREAM, bit_valid[k] and bit_last[k] both high: that bit is still evaluated for a match; go to DONE.
REQ-026 STREAM, req[k] deasserted without bit_last: abort to DONE; bits offered that cycle are discarded.
REQ-027 DONE: gnt all zero for one cycle; record k as last granted; return to IDLE.
  - Guarantees a minimum one-cycle grant gap between streams.
REQ-028 cfg_we is ignored outside IDLE; the active pattern never changes mid-stream.
REQ-029 gnt is one-hot only in STREAM and zero in all other states.

Reset
REQ-030 Reset assertion forces, asynchronously:
  - state IDLE, gnt 0, match 0, match_id 0, busy 0;
  - all counters 0, history 0, fill count 0, last-granted pointer NREQ-1;
  - pattern all zeros, len PAT_W.
REQ-031 Reset asserted mid-stream aborts the stream; no partial match is reported after reset release.

Structure
REQ-032 Shared package seq_match_pkg holds the FSM state enum and the default PAT_W/NREQ/CNT_W constants.
REQ-033 The round-robin selector is a sub-module rr_arbiter, combinational: inputs req and last pointer; output one-hot winner.

Verification
REQ-034 Config: pattern=8'b0000_0101, len=3; requester 0 streams 1,0,1,0,1 (last on final bit).
  - Expect match pulses after bits 3 and 5, match_id=0, counter0=2.
REQ-035 Round-robin: req=4'b1111 held.
  - Grants in order 0,1,2,3,0, each followed by one DONE cycle with gnt=0.
REQ-036 Saturation with CNT_W=2, len=1, pattern bit0=1: six valid 1-bits on requester 2.
  - Expect counter2 holds 3.
  - Then cnt_clr coincident with a match yields 0.
REQ-037 Abort: requester 1 drops req after two bits of a 3-bit pattern.
  - Expect DONE, then IDLE, no match, counter1 unchanged.
  - Next grant goes to requester 2 if requesting.
REQ-038 cfg_we during STREAM with a new pattern is ignored.
  - A match on the old pattern is still reported.
REQ-039 Reset pulse mid-STREAM: gnt=0, busy=0, counters=0 immediately.
  - The first grant after release goes to requester 0.
